hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage RV32 core (IF/ID/EX/MEM/WB). Detects RAW hazards, drives operand

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/fwd_unit.sv | 25 ++
 rtl/hazard_stall_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding, forwarding selects and flush bit indices for hazard_stall_ctrl
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int FLUSH_IFID  = 0;
    localparam int FLUSH_IDEX  = 1;
    localparam int FLUSH_EXMEM = 2;

    localparam logic [2:0] FLUSH_ALL = (3'b001 << FLUSH_EXMEM) | (3'b001 << FLUSH_IDEX)
                                     | (3'b001 << FLUSH_IFID);

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - per-operand forwarding select, EX/MEM result preferred over MEM/WB
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] i_ex_rs,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_we,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_we,
    output logic [1:0] o_fwd
);

    always_comb begin
        o_fwd = FWD_RF;
        // x0 is hardwired zero, so a producer targeting it never forwards
        if (i_ex_rs != 5'd0) begin
            if (i_mem_we && (i_mem_rd == i_ex_rs)) begin
                o_fwd = FWD_EXMEM;
            end else if (i_wb_we && (i_wb_rd == i_ex_rs)) begin
                o_fwd = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - 5-stage pipeline stall/flush/forwarding sequencer
// Optional perf counters when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter logic [2:0] FLUSH_MASK  = FLUSH_ALL,
    parameter int         MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int         CNT_W       = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use1,
    input  logic       i_id_use2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_we,
    input  logic       i_ex_load,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_we,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_we,
    input  logic [4:0] i_ex_rs1,
    input  logic [4:0] i_ex_rs2,
    input  logic       i_redirect,
    input  logic       i_mem_req,
    input  logic       i_mem_ready,
    output logic       o_stall_pc,
    output logic       o_stall_if_id,
    output logic       o_stall_id_ex,
    output logic       o_stall_ex_mem,
    output logic [2:0] o_flush,
    output logic       o_bubble_mem_wb,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b,
    output logic       o_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] o_cnt_lduse,
    output logic [CNT_W-1:0] o_cnt_flush,
    output logic [CNT_W-1:0] o_cnt_memwait
`endif
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    state_e      r_state;
    logic [15:0] r_wait_cnt;
    logic        r_pend_redir;

    logic        w_mem_stall;
    logic        w_timeout;
    logic        w_lduse_hit;
    logic        w_flush_fire;
    logic        w_lduse_fire;

    // The cycle DRAM completes is not stalled: MEM/WB captures the returned data
    always_comb begin
        w_mem_stall = 1'b0;
        case (r_state)
            ST_RUN:      w_mem_stall = i_mem_req && !i_mem_ready;
            ST_MEM_WAIT: w_mem_stall = !i_mem_ready;
            ST_ERR:      w_mem_stall = 1'b1;
            default:     w_mem_stall = 1'b1;
        endcase
    end

    assign w_timeout   = (MEM_TIMEOUT > 0) && (r_wait_cnt == TIMEOUT_LAST);
    assign w_lduse_hit = i_ex_load && i_ex_we && (i_ex_rd != 5'd0)
                      && ((i_id_use1 && (i_id_rs1 == i_ex_rd))
                       || (i_id_use2 && (i_id_rs2 == i_ex_rd)));

    // A redirect (live or deferred) squashes the ID instruction, so no load-use stall is needed
    assign w_flush_fire = !w_mem_stall && (i_redirect || r_pend_redir);
    assign w_lduse_fire = !w_mem_stall && !(i_redirect || r_pend_redir) && w_lduse_hit;

    always_comb begin
        o_stall_pc      = w_mem_stall || w_lduse_fire;
        o_stall_if_id   = w_mem_stall || w_lduse_fire;
        o_stall_id_ex   = w_mem_stall;
        o_stall_ex_mem  = w_mem_stall;
        o_bubble_mem_wb = w_mem_stall;
        o_flush         = 3'b000;
        if (w_flush_fire) begin
            o_flush = FLUSH_MASK;
        end else if (w_lduse_fire) begin
            o_flush[FLUSH_IDEX] = 1'b1;
        end
    end

    assign o_err = (r_state == ST_ERR);

    fwd_unit u_fwd_a (
        .i_ex_rs  (i_ex_rs1),
        .i_mem_rd (i_mem_rd),
        .i_mem_we (i_mem_we),
        .i_wb_rd  (i_wb_rd),
        .i_wb_we  (i_wb_we),
        .o_fwd    (o_fwd_a)
    );

    fwd_unit u_fwd_b (
        .i_ex_rs  (i_ex_rs2),
        .i_mem_rd (i_mem_rd),
        .i_mem_we (i_mem_we),
        .i_wb_rd  (i_wb_rd),
        .i_wb_we  (i_wb_we),
        .o_fwd    (o_fwd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_wait_cnt   <= 16'd0;
            r_pend_redir <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_mem_req && !i_mem_ready) begin
                        r_state    <= w_timeout ? ST_ERR : ST_MEM_WAIT;
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (i_mem_ready) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= 16'd0;
                    end else if (w_timeout) begin
                        r_state    <= ST_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= 16'd0;
                end
            endcase

            // Redirects arriving while frozen collapse into one flush on the first free cycle
            if (w_mem_stall) begin
                r_pend_redir <= r_pend_redir || i_redirect;
            end else begin
                r_pend_redir <= 1'b0;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_cnt_lduse;
    logic [CNT_W-1:0] r_cnt_flush;
    logic [CNT_W-1:0] r_cnt_memwait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_lduse   <= '0;
            r_cnt_flush   <= '0;
            r_cnt_memwait <= '0;
        end else begin
            if (w_lduse_fire && (r_cnt_lduse != '1)) begin
                r_cnt_lduse <= r_cnt_lduse + 1'b1;
            end
            if (w_flush_fire && (r_cnt_flush != '1)) begin
                r_cnt_flush <= r_cnt_flush + 1'b1;
            end
            if (w_mem_stall && (r_cnt_memwait != '1)) begin
                r_cnt_memwait <= r_cnt_memwait + 1'b1;
            end
        end
    end

    assign o_cnt_lduse   = r_cnt_lduse;
    assign o_cnt_flush   = r_cnt_flush;
    assign o_cnt_memwait = r_cnt_memwait;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed vector bench for hazard_stall_ctrl (MEM_TIMEOUT=4)
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2;
    logic       id_use1, id_use2, ex_we, ex_load, mem_we, wb_we;
    logic       redirect, mem_req, mem_ready;
    logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_mem_wb, err;
    logic [2:0] flush;
    logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] cnt_lduse, cnt_flush, cnt_memwait;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble, flush[2:0], fwd_a, fwd_b, err}
    logic [12:0] got;
    assign got = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_mem_wb,
                  flush, fwd_a, fwd_b, err};

    localparam logic [12:0] E_IDLE = 13'b0_0_0_0_0_000_00_00_0;
    localparam logic [12:0] E_LU   = 13'b1_1_0_0_0_010_00_00_0;
    localparam logic [12:0] E_RD   = 13'b0_0_0_0_0_111_00_00_0;
    localparam logic [12:0] E_MS   = 13'b1_1_1_1_1_000_00_00_0;
    localparam logic [12:0] E_MSE  = 13'b1_1_1_1_1_000_00_00_1;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_id_rs1        (id_rs1),
        .i_id_rs2        (id_rs2),
        .i_id_use1       (id_use1),
        .i_id_use2       (id_use2),
        .i_ex_rd         (ex_rd),
        .i_ex_we         (ex_we),
        .i_ex_load       (ex_load),
        .i_mem_rd        (mem_rd),
        .i_mem_we        (mem_we),
        .i_wb_rd         (wb_rd),
        .i_wb_we         (wb_we),
        .i_ex_rs1        (ex_rs1),
        .i_ex_rs2        (ex_rs2),
        .i_redirect      (redirect),
        .i_mem_req       (mem_req),
        .i_mem_ready     (mem_ready),
        .o_stall_pc      (stall_pc),
        .o_stall_if_id   (stall_if_id),
        .o_stall_id_ex   (stall_id_ex),
        .o_stall_ex_mem  (stall_ex_mem),
        .o_flush         (flush),
        .o_bubble_mem_wb (bubble_mem_wb),
        .o_fwd_a         (fwd_a),
        .o_fwd_b         (fwd_b),
        .o_err           (err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_cnt_lduse     (cnt_lduse),
        .o_cnt_flush     (cnt_flush),
        .o_cnt_memwait   (cnt_memwait)
`endif
    );

    typedef struct {
        string       name;
        logic [4:0]  id_rs1, id_rs2;
        logic        id_use1, id_use2;
        logic [4:0]  ex_rd;
        logic        ex_we, ex_load;
        logic [4:0]  mem_rd;
        logic        mem_we;
        logic [4:0]  wb_rd;
        logic        wb_we;
        logic [4:0]  ex_rs1, ex_rs2;
        logic        redirect, mem_req, mem_ready;
        logic [12:0] exp;
    } vec_t;

    vec_t vt[15];

    task automatic clr_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use1 = 1'b0; id_use2 = 1'b0;
        ex_rd = 5'd0; ex_we = 1'b0; ex_load = 1'b0;
        mem_rd = 5'd0; mem_we = 1'b0; wb_rd = 5'd0; wb_we = 1'b0;
        ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_use1 = v.id_use1; id_use2 = v.id_use2;
        ex_rd = v.ex_rd; ex_we = v.ex_we; ex_load = v.ex_load;
        mem_rd = v.mem_rd; mem_we = v.mem_we; wb_rd = v.wb_rd; wb_we = v.wb_we;
        ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2;
        redirect = v.redirect; mem_req = v.mem_req; mem_ready = v.mem_ready;
    endtask

    task automatic chk(input string nm, input logic [12:0] exp);
        #1;
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (stalls,bubble,flush,fwd_a,fwd_b,err)", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clr_in();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //        name          idrs1 idrs2 u1    u2    exrd  exwe  ld    memrd mwe   wbrd  wbwe  exrs1 exrs2 redir req   rdy   exp
        vt[0]  = '{"idle",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE};
        vt[1]  = '{"lu_rs1",    5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_LU};
        vt[2]  = '{"lu_rs2",    5'd2, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_LU};
        vt[3]  = '{"lu_nouse",  5'd5, 5'd1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE};
        vt[4]  = '{"lu_x0",     5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE};
        vt[5]  = '{"lu_notld",  5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE};
        vt[6]  = '{"lu_nowe",   5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE};
        vt[7]  = '{"fwd_exmem", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 13'b0_0_0_0_0_000_01_00_0};
        vt[8]  = '{"fwd_x0",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE};
        vt[9]  = '{"fwd_b_wb",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 5'd9, 1'b1, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 13'b0_0_0_0_0_000_00_10_0};
        vt[10] = '{"fwd_both",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 13'b0_0_0_0_0_000_01_10_0};
        vt[11] = '{"fwd_nowe",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 5'd3, 1'b0, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, E_IDLE};
        vt[12] = '{"redir_lu",  5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_RD};
        vt[13] = '{"redir",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_RD};
        vt[14] = '{"memrdy_lu", 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, E_LU};

        clr_in();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset", E_IDLE);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            apply_vec(vt[i]);
            chk(vt[i].name, vt[i].exp);
        end

        do_reset();

        // lw x5 ; add x6,x5,x1 : one bubble, then MEM/WB forward
        @(negedge clk); clr_in();
        id_rs1 = 5'd5; id_rs2 = 5'd1; id_use1 = 1'b1; id_use2 = 1'b1;
        ex_rd = 5'd5; ex_we = 1'b1; ex_load = 1'b1;
        chk("s1_lduse", E_LU);
        @(negedge clk); clr_in();
        id_rs1 = 5'd5; id_rs2 = 5'd1; id_use1 = 1'b1; id_use2 = 1'b1;
        mem_rd = 5'd5; mem_we = 1'b1;
        chk("s1_bubble", E_IDLE);
        @(negedge clk); clr_in();
        ex_rd = 5'd6; ex_we = 1'b1; ex_rs1 = 5'd5; ex_rs2 = 5'd1;
        wb_rd = 5'd5; wb_we = 1'b1;
        chk("s1_fwd_wb", 13'b0_0_0_0_0_000_10_00_0);

        @(negedge clk); clr_in();
        id_rs1 = 5'd5; id_use1 = 1'b1; ex_rd = 5'd5; ex_we = 1'b1; ex_load = 1'b1;
        redirect = 1'b1;
        chk("s3_redir_lu", E_RD);

        // three-cycle DRAM wait with two redirects absorbed into one flush
        @(negedge clk); clr_in(); mem_req = 1'b1;
        chk("s4_c0", E_MS);
        @(negedge clk); clr_in(); mem_req = 1'b1; redirect = 1'b1;
        id_rs1 = 5'd5; id_use1 = 1'b1; ex_rd = 5'd5; ex_we = 1'b1; ex_load = 1'b1;
        chk("s4_c1_redir", E_MS);
        @(negedge clk); clr_in(); mem_req = 1'b1; redirect = 1'b1;
        chk("s4_c2_redir", E_MS);
        @(negedge clk); clr_in(); mem_req = 1'b1; mem_ready = 1'b1;
        chk("s4_ready_flush", E_RD);
        @(negedge clk); clr_in();
        chk("s4_after", E_IDLE);

`ifdef HAZARD_PERF_CNT_EN
        #1;
        n_vec++;
        if ({cnt_lduse, cnt_flush, cnt_memwait} !== {32'd1, 32'd2, 32'd3}) begin
            n_bad++;
            $display("FAIL perf_cnt: got lduse=%0d flush=%0d memwait=%0d expected 1 2 3",
                     cnt_lduse, cnt_flush, cnt_memwait);
        end
`endif

        // second wait must start with a cleared wait counter
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); clr_in(); mem_req = 1'b1;
            chk($sformatf("s4b_wait%0d", c), E_MS);
        end
        @(negedge clk); clr_in(); mem_req = 1'b1; mem_ready = 1'b1;
        chk("s4b_ready", E_IDLE);

        // timeout: four stalled cycles then sticky err
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); clr_in(); mem_req = 1'b1;
            chk($sformatf("s5_wait%0d", c), E_MS);
        end
        @(negedge clk); clr_in(); mem_req = 1'b1;
        chk("s5_err", E_MSE);
        @(negedge clk); clr_in(); mem_req = 1'b1; mem_ready = 1'b1; redirect = 1'b1;
        chk("s5_err_sticky", E_MSE);
        @(negedge clk); clr_in();
        chk("s5_err_noreq", E_MSE);
        rst_n = 1'b0;
        chk("s5_async_rst", E_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        chk("s5_pend_dropped", E_IDLE);
        @(negedge clk); clr_in();
        id_rs2 = 5'd8; id_use2 = 1'b1; ex_rd = 5'd8; ex_we = 1'b1; ex_load = 1'b1;
        chk("s5_run_lduse", E_LU);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
